// File: rtl/dataflow_pkg.sv
// Shared definitions for the dataflow req/ack building blocks.
package dataflow_pkg;

  localparam int unsigned DefaultDataWidth = 32;

  // FIFO depths must be a power of two and hold at least two words.
  function automatic bit is_pow2_depth(int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Circular-buffer storage with wrap-bit pointers and full/empty/level status.
module sync_fifo_mem
  import dataflow_pkg::*;
#(
  parameter int unsigned data_width = DefaultDataWidth,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [data_width-1:0] wr_data,
  input  logic                  rd_en,
  output logic [data_width-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [addr_width:0]   level
);

  logic [data_width-1:0] mem_q [depth];
  logic [addr_width:0]   wptr_q, rptr_q;
  logic                  push, pop;

  // Pointers differ only in the wrap bit when every slot is occupied.
  assign full    = (wptr_q ^ rptr_q) == {1'b1, {addr_width{1'b0}}};
  assign empty   = (wptr_q == rptr_q);
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign level   = wptr_q - rptr_q;
  assign rd_data = mem_q[rptr_q[addr_width-1:0]];

  // Pointer advance; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wptr_q[addr_width-1:0]] <= wr_data;
  end

endmodule

// File: rtl/reqack_source_fifo.sv
// Buffered req/ack responder: queues a valid/ready stream and serves it as ack pulses.
module reqack_source_fifo
  import dataflow_pkg::*;
#(
  parameter int unsigned data_width = DefaultDataWidth,
  parameter int unsigned depth      = 4,
  parameter int unsigned addr_width = $clog2(depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [data_width-1:0] s_data,
  input  logic                  req,
  output logic                  ack,
  output logic [data_width-1:0] dout,
  output logic [addr_width:0]   level,
  output logic [31:0]           count
);

  if (!is_pow2_depth(depth)) begin : g_depth_check
    $error("reqack_source_fifo: depth must be a power of two and at least 2");
  end

  logic                  full, empty, pop;
  logic [data_width-1:0] rd_data;
  logic                  ack_q, ack_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [31:0]           count_q, count_d;

  sync_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .addr_width (addr_width)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Pop control: serve a pending req only in a cycle after an ack-low cycle.
  always_comb begin
    pop     = req & ~ack_q & ~empty;
    ack_d   = pop;
    dout_d  = dout_q;
    count_d = count_q;
    if (pop) begin
      dout_d  = rd_data;
      count_d = count_q + 32'd1;
    end
  end

  // Response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      dout_q  <= '0;
      count_q <= '0;
    end else begin
      ack_q   <= ack_d;
      dout_q  <= dout_d;
      count_q <= count_d;
    end
  end

  assign s_ready = ~full;
  assign ack     = ack_q;
  assign dout    = dout_q;
  assign count   = count_q;

endmodule

// File: tb/tb_reqack_source_fifo.sv
// Self-checking bench: queue-level reference model plus directed and random stimulus.
module tb_reqack_source_fifo;

  localparam int unsigned Depth = 4;
  localparam int unsigned NStream = 5000;

  logic        clk, rst, s_valid, s_ready, req, ack;
  logic [31:0] s_data, dout, count;
  logic [2:0]  level;

  int vectors = 0;
  int miscompares = 0;

  reqack_source_fifo #(
    .data_width (32),
    .depth      (Depth)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .req     (req),
    .ack     (ack),
    .dout    (dout),
    .level   (level),
    .count   (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc_cnt, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Reference model: a word queue plus the last delivered word.
  logic [31:0] mq[$];
  bit          m_ack = 1'b0;
  logic [31:0] m_dout = '0;
  int unsigned m_count = 0;
  bit          model_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ack = 1'b0;
      m_dout = '0;
      m_count = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin : upd
      bit do_pop, do_push;
      do_pop  = req && !m_ack && (mq.size() > 0);
      do_push = s_valid && (mq.size() < Depth);
      if (do_pop) begin
        m_dout = mq.pop_front();
        m_count++;
      end
      m_ack = do_pop;
      if (do_push) mq.push_back(s_data);
    end
  end

  // Every-cycle comparison against the model once it has seen a reset.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("ack", {31'd0, ack}, {31'd0, m_ack});
      chk("dout", dout, m_dout);
      chk("count", count, m_count);
      chk("level", {29'd0, level}, mq.size());
      chk("s_ready", {31'd0, s_ready}, {31'd0, (mq.size() < Depth)});
    end
  end

  // Streaming consumer: words must arrive as 0,1,2,... on alternate cycles.
  bit stream_on = 1'b0;
  int rcv = 0;
  int first_ack_cyc = 0;
  int last_ack_cyc = 0;
  always @(negedge clk) begin
    if (stream_on && ack) begin
      chk("stream_word", dout, rcv);
      if (rcv == 0) first_ack_cyc = cyc_cnt;
      last_ack_cyc = cyc_cnt;
      rcv++;
    end
  end

  initial begin
    logic [31:0] got[$];
    int idx, guard, found;
    bit acc;

    // Reset values with req and s_valid asserted.
    rst = 1'b1; req = 1'b1; s_valid = 1'b1; s_data = 32'hDEAD_BEEF;
    cyc(); cyc();
    chk("rst_ack", {31'd0, ack}, 0);
    chk("rst_dout", dout, 0);
    chk("rst_count", count, 0);
    chk("rst_level", {29'd0, level}, 0);
    chk("rst_s_ready", {31'd0, s_ready}, 1);
    rst = 1'b0; s_valid = 1'b0; req = 1'b0;
    cyc();

    // Single word with req held high.
    s_valid = 1'b1; s_data = 32'h5; req = 1'b1;
    cyc();
    s_valid = 1'b0;
    chk("single_e_ack", {31'd0, ack}, 0);
    chk("single_e_level", {29'd0, level}, 1);
    cyc();
    chk("single_e1_ack", {31'd0, ack}, 1);
    chk("single_e1_dout", dout, 5);
    cyc();
    chk("single_e2_ack", {31'd0, ack}, 0);
    chk("single_e2_dout", dout, 5);
    chk("single_count", count, 1);
    req = 1'b0;
    cyc();

    // Fill to full, try one extra word, then drain.
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 32'(10 + i);
      cyc();
    end
    chk("fill_s_ready", {31'd0, s_ready}, 0);
    chk("fill_level", {29'd0, level}, 4);
    s_data = 32'd14;
    cyc();
    chk("fill_reject_level", {29'd0, level}, 4);
    s_valid = 1'b0; req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("drain_ack_pattern", {31'd0, ack}, (k % 2 == 0) ? 1 : 0);
      if (k == 0) chk("drain_s_ready", {31'd0, s_ready}, 1);
      if (ack) got.push_back(dout);
    end
    chk("drain_n", got.size(), 4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk("drain_word", got[k], 32'(10 + k));
    req = 1'b0;
    cyc();

    // Streaming 0..NStream-1 with req held high.
    rst = 1'b1; cyc(); rst = 1'b0;
    stream_on = 1'b1; req = 1'b1;
    idx = 0; guard = 0;
    while (idx < NStream && guard < 30000) begin
      s_valid = 1'b1; s_data = idx;
      acc = s_ready;
      cyc();
      if (acc) idx++;
      guard++;
    end
    s_valid = 1'b0;
    guard = 0;
    while (rcv < NStream && guard < 100) begin
      cyc();
      guard++;
    end
    chk("stream_pushed", idx, NStream);
    chk("stream_rcv", rcv, NStream);
    chk("stream_count", count, NStream);
    chk("stream_span", last_ack_cyc - first_ack_cyc, 2 * (NStream - 1));
    stream_on = 1'b0; req = 1'b0;
    cyc();

    // Empty with req pending, then one word.
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk("empty_no_ack", {31'd0, ack}, 0);
    end
    s_valid = 1'b1; s_data = 32'hA5;
    cyc();
    s_valid = 1'b0;
    chk("empty_accept_ack", {31'd0, ack}, 0);
    cyc();
    chk("empty_late_ack", {31'd0, ack}, 1);
    chk("empty_late_dout", dout, 32'hA5);
    req = 1'b0;
    cyc();

    // Reset while ack is high and three words remain.
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      s_valid = 1'b1; s_data = i;
      cyc();
    end
    s_valid = 1'b0; req = 1'b1;
    cyc();
    chk("mid_ack", {31'd0, ack}, 1);
    chk("mid_level", {29'd0, level}, 3);
    chk("mid_dout", dout, 1);
    rst = 1'b1; req = 1'b0;
    cyc();
    chk("mid_rst_ack", {31'd0, ack}, 0);
    chk("mid_rst_level", {29'd0, level}, 0);
    chk("mid_rst_count", count, 0);
    rst = 1'b0; s_valid = 1'b1; s_data = 32'd7; req = 1'b1;
    cyc();
    s_valid = 1'b0;
    found = 0; guard = 0;
    while (!found && guard < 10) begin
      if (ack) found = 1;
      else begin
        cyc();
        guard++;
      end
    end
    chk("mid_after_found", found, 1);
    chk("mid_after_dout", dout, 7);
    req = 1'b0;
    cyc();

    // Random traffic, varying push/pull density, rare resets.
    for (int blk = 0; blk < 3; blk++) begin
      for (int k = 0; k < 1000; k++) begin
        rst     = ($urandom_range(0, 199) == 0);
        s_valid = ($urandom_range(0, 3) < (blk + 1));
        req     = ($urandom_range(0, 3) >= blk);
        s_data  = $urandom;
        cyc();
      end
    end
    rst = 1'b0; s_valid = 1'b0; req = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
